count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer_pkg.sv | 30 +++
 rtl/updown_counter4.sv | 28 ++
 rtl/count_sequencer.sv | 133 +++++++++++++
 tb/tb_count_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared state encodings, default ramp geometry and the state-to-lamp decode
// for the count sequencer.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int CNT_W       = 4;
  localparam int SEG_DEFAULT = 4;
  localparam int TOP_DEFAULT = 15;

  // One-hot indicator pattern {red, amber, green} for a given state.
  function automatic logic [2:0] lamps(input state_t s);
    logic [2:0] l;
    l = 3'b100;
    case (s)
      IDLE:      l = 3'b100;
      RAMP_UP:   l = 3'b010;
      HOLD:      l = 3'b001;
      RAMP_DOWN: l = 3'b010;
      default:   l = 3'b100;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/updown_counter4.sv
// 4-bit up/down counter that saturates at TOP going up and at 0 going down;
// clear has priority over counting.
module updown_counter4 #(
  parameter logic [3:0] TOP = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       forward,
  input  logic       clear,
  output logic [3:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (en) begin
      if (forward) begin
        if (count != TOP) count <= count + 4'd1;
      end else begin
        if (count != 4'd0) count <= count - 4'd1;
      end
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Ramp sequencer: IDLE -> RAMP_UP -> HOLD, with requested up/down ramps of SEG
// counts out of HOLD, saturating at TOP and 0, plus done/limit pulses.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int SEG = SEG_DEFAULT,
  parameter int TOP = TOP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       progressive,
  input  logic       regressive,
  input  logic       abort,
  output logic [3:0] count,
  output logic [1:0] state,
  output logic       red,
  output logic       amber,
  output logic       green,
  output logic       cnt_forward,
  output logic       done,
  output logic       limit
);

  localparam logic [3:0] SEG_C = 4'(SEG);
  localparam logic [3:0] TOP_C = 4'(TOP);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] seg_q;
  logic [3:0] seg_d;
  logic [3:0] cnt_next;
  logic       cnt_en;
  logic       cnt_fwd;
  logic       cnt_clr;
  logic       done_d;
  logic       limit_d;

  updown_counter4 #(
    .TOP(TOP_C)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (cnt_en),
    .forward(cnt_fwd),
    .clear  (cnt_clr),
    .count  (count)
  );

  // Ramp termination looks at the count the counter will hold after this edge,
  // so the final count and the new state land on the same edge.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    cnt_next = count;
    cnt_en   = 1'b0;
    cnt_fwd  = 1'b1;
    cnt_clr  = 1'b0;
    done_d   = 1'b0;
    limit_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      seg_d   = 4'd0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RAMP_UP;
            seg_d   = SEG_C;
          end
        end
        RAMP_UP: begin
          cnt_en   = 1'b1;
          cnt_fwd  = 1'b1;
          cnt_next = (count == TOP_C) ? count : count + 4'd1;
          seg_d    = (seg_q == 4'd0) ? 4'd0 : seg_q - 4'd1;
          if (seg_d == 4'd0 || cnt_next == TOP_C) state_d = HOLD;
        end
        HOLD: begin
          if (progressive && !regressive) begin
            if (count < TOP_C) begin
              state_d = RAMP_UP;
              seg_d   = SEG_C;
            end else begin
              limit_d = 1'b1;
            end
          end else if (regressive && !progressive) begin
            state_d = RAMP_DOWN;
            seg_d   = SEG_C;
          end
        end
        RAMP_DOWN: begin
          cnt_en   = 1'b1;
          cnt_fwd  = 1'b0;
          cnt_next = (count == 4'd0) ? 4'd0 : count - 4'd1;
          seg_d    = (seg_q == 4'd0) ? 4'd0 : seg_q - 4'd1;
          if (cnt_next == 4'd0) begin
            state_d = IDLE;
            seg_d   = 4'd0;
            done_d  = 1'b1;
          end else if (seg_d == 4'd0) begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      seg_q       <= 4'd0;
      red         <= 1'b1;
      amber       <= 1'b0;
      green       <= 1'b0;
      cnt_forward <= 1'b1;
      done        <= 1'b0;
      limit       <= 1'b0;
    end else begin
      state_q               <= state_d;
      seg_q                 <= seg_d;
      {red, amber, green}   <= lamps(state_d);
      cnt_forward           <= (state_d != RAMP_DOWN);
      done                  <= done_d;
      limit                 <= limit_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with hand-computed expected sequences.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       progressive;
  logic       regressive;
  logic       abort;
  logic [3:0] count;
  logic [1:0] state;
  logic       red;
  logic       amber;
  logic       green;
  logic       cnt_forward;
  logic       done;
  logic       limit;

  int tests = 0;
  int fails = 0;

  count_sequencer #(.SEG(4), .TOP(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .progressive(progressive),
    .regressive (regressive),
    .abort      (abort),
    .count      (count),
    .state      (state),
    .red        (red),
    .amber      (amber),
    .green      (green),
    .cnt_forward(cnt_forward),
    .done       (done),
    .limit      (limit)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                      input logic dn, input logic lm);
    tick();
    check({tag, "_state"}, 8'(state), 8'(st));
    check({tag, "_count"}, 8'(count), 8'(cnt));
    check({tag, "_done"},  8'(done),  8'(dn));
    check({tag, "_limit"}, 8'(limit), 8'(lm));
  endtask

  task automatic check_lamps(input string tag, input logic [2:0] rag, input logic fwd);
    check({tag, "_lamps"}, 8'({red, amber, green}), 8'(rag));
    check({tag, "_fwd"},   8'(cnt_forward),        8'(fwd));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; progressive = 1'b0; regressive = 1'b0; abort = 1'b0;
    #12;
    check("rst_state", 8'(state), 8'd0);
    check("rst_count", 8'(count), 8'd0);
    check("rst_done",  8'(done),  8'd0);
    check("rst_limit", 8'(limit), 8'd0);
    check_lamps("rst", 3'b100, 1'b1);

    // Start honoured on the first edge after reset release
    reset = 1'b1; start = 1'b1;
    step("start_e0", 2'd1, 4'd0, 1'b0, 1'b0);
    check_lamps("start_e0", 3'b010, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step("up_seg", 2'd1, 4'(i), 1'b0, 1'b0);
    step("up_hold", 2'd2, 4'd4, 1'b0, 1'b0);
    check_lamps("up_hold", 3'b001, 1'b1);

    start = 1'b1;
    step("hold_start_ign", 2'd2, 4'd4, 1'b0, 1'b0);
    start = 1'b0;

    // Down ramp from 4 reaches 0 -> IDLE with done
    regressive = 1'b1;
    step("dn_enter", 2'd3, 4'd4, 1'b0, 1'b0);
    check_lamps("dn_enter", 3'b010, 1'b0);
    regressive = 1'b0;
    for (int i = 3; i >= 1; i--) step("dn_seg", 2'd3, 4'(i), 1'b0, 1'b0);
    step("dn_done", 2'd0, 4'd0, 1'b1, 1'b0);
    check_lamps("dn_done", 3'b100, 1'b1);
    step("dn_done_clr", 2'd0, 4'd0, 1'b0, 1'b0);

    // Progressive held: 4 -> 8 -> 12 -> 15 (TOP cuts the last ramp), then limit
    start = 1'b1;
    step("start2", 2'd1, 4'd0, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step("up2", 2'd1, 4'(i), 1'b0, 1'b0);
    step("up2_hold", 2'd2, 4'd4, 1'b0, 1'b0);
    progressive = 1'b1;
    for (int base = 4; base <= 8; base += 4) begin
      step("prog_enter", 2'd1, 4'(base), 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step("prog_ramp", 2'd1, 4'(base + i), 1'b0, 1'b0);
      step("prog_hold", 2'd2, 4'(base + 4), 1'b0, 1'b0);
    end
    step("prog_enter12", 2'd1, 4'd12, 1'b0, 1'b0);
    step("prog_13", 2'd1, 4'd13, 1'b0, 1'b0);
    step("prog_14", 2'd1, 4'd14, 1'b0, 1'b0);
    step("prog_top", 2'd2, 4'd15, 1'b0, 1'b0);
    step("prog_limit", 2'd2, 4'd15, 1'b0, 1'b1);
    progressive = 1'b0;
    step("limit_clr", 2'd2, 4'd15, 1'b0, 1'b0);

    // Conflicting requests: nothing moves
    progressive = 1'b1; regressive = 1'b1;
    for (int i = 0; i < 5; i++) step("both", 2'd2, 4'd15, 1'b0, 1'b0);
    progressive = 1'b0;

    // Regressive held from 15: segments of 4 down to 3, then 3 -> 0 ends on count
    for (int base = 15; base >= 7; base -= 4) begin
      step("reg_enter", 2'd3, 4'(base), 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step("reg_ramp", 2'd3, 4'(base - i), 1'b0, 1'b0);
      step("reg_hold", 2'd2, 4'(base - 4), 1'b0, 1'b0);
    end
    step("reg_enter3", 2'd3, 4'd3, 1'b0, 1'b0);
    step("reg_2", 2'd3, 4'd2, 1'b0, 1'b0);
    step("reg_1", 2'd3, 4'd1, 1'b0, 1'b0);
    regressive = 1'b0;
    step("reg_zero", 2'd0, 4'd0, 1'b1, 1'b0);

    // Abort mid RAMP_UP, and abort beats start in IDLE
    start = 1'b1;
    step("ab_start", 2'd1, 4'd0, 1'b0, 1'b0);
    start = 1'b0;
    step("ab_1", 2'd1, 4'd1, 1'b0, 1'b0);
    step("ab_2", 2'd1, 4'd2, 1'b0, 1'b0);
    abort = 1'b1;
    step("abort", 2'd0, 4'd0, 1'b0, 1'b0);
    start = 1'b1;
    step("abort_prio", 2'd0, 4'd0, 1'b0, 1'b0);
    abort = 1'b0;
    step("restart", 2'd1, 4'd0, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step("up3", 2'd1, 4'(i), 1'b0, 1'b0);
    step("up3_hold", 2'd2, 4'd4, 1'b0, 1'b0);

    // Asynchronous reset mid RAMP_DOWN
    regressive = 1'b1;
    step("rd_enter", 2'd3, 4'd4, 1'b0, 1'b0);
    step("rd_3", 2'd3, 4'd3, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("arst_state", 8'(state), 8'd0);
    check("arst_count", 8'(count), 8'd0);
    check("arst_done",  8'(done),  8'd0);
    check_lamps("arst", 3'b100, 1'b1);
    regressive = 1'b0; start = 1'b1;
    #2;
    reset = 1'b1;
    step("arst_restart", 2'd1, 4'd0, 1'b0, 1'b0);
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
